// File: rtl/bp_fe_pred_update_sched_if.sv
// bp_fe_pred_update_sched_if: update-source and table-write bundle for the predictor update scheduler.
interface bp_fe_pred_update_sched_if #(
  parameter int idx_width_p  = 6,
  parameter int data_width_p = 8,
  parameter int fifo_els_p   = 4
);
  localparam int cw = $clog2(fifo_els_p + 1);
  logic                    init_done_o;
  logic                    redir_v_i;
  logic [idx_width_p-1:0]  redir_idx_i;
  logic [data_width_p-1:0] redir_data_i;
  logic                    redir_drop_o;
  logic                    att_v_i;
  logic                    att_ready_o;
  logic [idx_width_p-1:0]  att_idx_i;
  logic [data_width_p-1:0] att_data_i;
  logic                    flush_i;
  logic                    w_v_o;
  logic [idx_width_p-1:0]  w_idx_o;
  logic [data_width_p-1:0] w_data_o;
  logic                    w_clr_o;
  logic                    w_correct_o;
  logic                    w_yumi_i;
  logic [cw-1:0]           fifo_count_o;
  modport master (
    output redir_v_i, redir_idx_i, redir_data_i, att_v_i, att_idx_i, att_data_i, flush_i, w_yumi_i,
    input  init_done_o, redir_drop_o, att_ready_o, w_v_o, w_idx_o, w_data_o, w_clr_o, w_correct_o, fifo_count_o
  );
  modport slave (
    input  redir_v_i, redir_idx_i, redir_data_i, att_v_i, att_idx_i, att_data_i, flush_i, w_yumi_i,
    output init_done_o, redir_drop_o, att_ready_o, w_v_o, w_idx_o, w_data_o, w_clr_o, w_correct_o, fifo_count_o
  );
endinterface

// File: rtl/bp_fe_pred_update_sched.sv
// bp_fe_pred_update_sched: sweeps the predictor table clear, then arbitrates redirect and attaboy writes.
module bp_fe_pred_update_sched #(
  parameter int idx_width_p  = 6,
  parameter int data_width_p = 8,
  parameter int fifo_els_p   = 4,
  parameter logic [data_width_p-1:0] init_val_p = 8'h55
) (
  input logic clk_i,
  input logic reset_n_i,
  bp_fe_pred_update_sched_if.slave u
);
  localparam int cw = $clog2(fifo_els_p + 1);
  localparam int pw = $clog2(fifo_els_p);
  localparam logic [1:0] e_reset = 2'd0, e_init = 2'd1, e_run = 2'd2;
  logic [1:0]              state;
  logic [idx_width_p-1:0]  ctr, held_idx;
  logic [data_width_p-1:0] held_data;
  logic                    held_v, drop;
  logic [idx_width_p-1:0]  q_idx  [fifo_els_p];
  logic [data_width_p-1:0] q_data [fifo_els_p];
  logic [pw-1:0]           rd, wr;
  logic [cw-1:0]           count;
  logic run, init, fifo_v, yumi_held, yumi_fifo, cap, enq;
  always_comb begin
    run       = state == e_run;
    init      = state == e_init;
    fifo_v    = count != '0;
    yumi_held = u.w_yumi_i & run & held_v;
    yumi_fifo = u.w_yumi_i & run & ~held_v & fifo_v;
    cap       = run & u.redir_v_i & ~u.flush_i;
    enq       = u.att_v_i & u.att_ready_o & ~u.flush_i;
  end
  // Held redirect always wins over the attaboy queue head.
  assign u.att_ready_o  = run & (count < cw'(fifo_els_p));
  assign u.init_done_o  = run;
  assign u.redir_drop_o = drop;
  assign u.fifo_count_o = count;
  assign u.w_v_o        = init | (run & (held_v | fifo_v));
  assign u.w_clr_o      = init;
  assign u.w_correct_o  = run & ~held_v & fifo_v;
  assign u.w_idx_o      = init ? ctr : held_v ? held_idx : q_idx[rd];
  assign u.w_data_o     = init ? init_val_p : held_v ? held_data : q_data[rd];
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state  <= e_reset;
      ctr    <= '0;
      held_v <= 1'b0;
      drop   <= 1'b0;
      rd     <= '0;
      wr     <= '0;
      count  <= '0;
    end else begin
      state  <= (state == e_reset) ? e_init : (init & u.w_yumi_i & (ctr == '1)) ? e_run : state;
      if (init & u.w_yumi_i) ctr <= ctr + idx_width_p'(1);
      held_v <= cap | (held_v & ~yumi_held & ~u.flush_i);
      if (cap) begin
        held_idx  <= u.redir_idx_i;
        held_data <= u.redir_data_i;
      end
      drop <= cap & held_v & ~yumi_held;
      if (u.flush_i) begin
        rd    <= '0;
        wr    <= '0;
        count <= '0;
      end else begin
        if (enq) wr <= wr + pw'(1);
        if (yumi_fifo) rd <= rd + pw'(1);
        count <= count + cw'(enq) - cw'(yumi_fifo);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (enq) begin
      q_idx[wr]  <= u.att_idx_i;
      q_data[wr] <= u.att_data_i;
    end
  end
endmodule

// File: tb/tb_bp_fe_pred_update_sched.sv
// tb_bp_fe_pred_update_sched: directed checks of sweep, queueing, redirect priority, drop, flush and reset.
module tb_bp_fe_pred_update_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errs = 0;
  bp_fe_pred_update_sched_if bus();
  bp_fe_pred_update_sched dut (.clk_i(clk), .reset_n_i(rst_n), .u(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    bus.redir_v_i = 0; bus.redir_idx_i = '0; bus.redir_data_i = '0;
    bus.att_v_i = 0; bus.att_idx_i = '0; bus.att_data_i = '0;
    bus.flush_i = 0; bus.w_yumi_i = 0;
  endtask
  task automatic bring_up();
    clear_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    bus.w_yumi_i = 1;
    repeat (65) tick();
    bus.w_yumi_i = 0;
  endtask
  task automatic enqueue(input logic [5:0] idx, input logic [7:0] data);
    bus.att_v_i = 1; bus.att_idx_i = idx; bus.att_data_i = data;
    tick();
    bus.att_v_i = 0;
  endtask
  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    bus.redir_v_i = 1; bus.att_v_i = 1; bus.redir_idx_i = 6'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({bus.w_v_o, bus.init_done_o, bus.att_ready_o, bus.redir_drop_o, bus.fifo_count_o} !== 7'b0) begin
        errs++;
        $display("FAIL reset_state[%0d]: got v=%b done=%b rdy=%b drop=%b cnt=%0d, want all 0", i,
                 bus.w_v_o, bus.init_done_o, bus.att_ready_o, bus.redir_drop_o, bus.fifo_count_o);
      end
    end
    clear_inputs();
  endtask
  task automatic test_sweep_fast();
    logic [21:0] got, exp;
    rst_n = 0; clear_inputs(); tick();
    rst_n = 1; bus.w_yumi_i = 1;
    tick();
    for (int i = 0; i < 64; i++) begin
      got = {bus.w_v_o, bus.w_clr_o, bus.w_correct_o, bus.init_done_o, bus.att_ready_o, bus.w_idx_o, bus.w_data_o, bus.fifo_count_o};
      exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'(i), 8'h55, 3'd0};
      vectors++;
      if (got !== exp) begin
        errs++;
        $display("FAIL sweep_fast[%0d]: got %h want %h", i, got, exp);
      end
      tick();
    end
    vectors++;
    if ({bus.init_done_o, bus.w_v_o, bus.att_ready_o} !== 3'b101) begin
      errs++;
      $display("FAIL init_done_cycle66: got done=%b v=%b rdy=%b want 1 0 1", bus.init_done_o, bus.w_v_o, bus.att_ready_o);
    end
    bus.w_yumi_i = 0;
    tick(); tick();
    vectors++;
    if (bus.init_done_o !== 1'b1) begin
      errs++;
      $display("FAIL init_done_held: got %b want 1", bus.init_done_o);
    end
  endtask
  task automatic test_sweep_slow();
    int exp_idx = 0;
    int c = 0;
    rst_n = 0; clear_inputs(); tick();
    rst_n = 1;
    bus.redir_v_i = 1; bus.redir_idx_i = 6'd33; bus.att_v_i = 1; bus.att_idx_i = 6'd44;
    tick();
    while (!bus.init_done_o && c < 400) begin
      bus.w_yumi_i = (c % 3 == 2);
      if (bus.w_yumi_i) begin
        vectors++;
        if ({bus.w_v_o, bus.w_clr_o, bus.att_ready_o, bus.w_idx_o} !== {3'b110, 6'(exp_idx)}) begin
          errs++;
          $display("FAIL sweep_slow[%0d]: got v=%b clr=%b rdy=%b idx=%0d want 1 1 0 %0d", exp_idx,
                   bus.w_v_o, bus.w_clr_o, bus.att_ready_o, bus.w_idx_o, exp_idx);
        end
        exp_idx++;
      end
      tick();
      c++;
    end
    clear_inputs();
    vectors++;
    if (exp_idx != 64 || !bus.init_done_o) begin
      errs++;
      $display("FAIL sweep_slow_count: got %0d writes done=%b want 64 1", exp_idx, bus.init_done_o);
    end
    vectors++;
    if ({bus.w_v_o, bus.fifo_count_o} !== 4'b0) begin
      errs++;
      $display("FAIL init_ignores_inputs: got v=%b cnt=%0d want 0 0", bus.w_v_o, bus.fifo_count_o);
    end
  endtask
  task automatic test_fifo_full();
    bring_up();
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (bus.att_ready_o !== (k < 4)) begin
        errs++;
        $display("FAIL fifo_ready[%0d]: got %b want %b", k, bus.att_ready_o, k < 4);
      end
      enqueue(6'(10 + k), 8'(8'hA0 + k));
    end
    vectors++;
    if ({bus.fifo_count_o, bus.att_ready_o} !== {3'd4, 1'b0}) begin
      errs++;
      $display("FAIL fifo_full: got cnt=%0d rdy=%b want 4 0", bus.fifo_count_o, bus.att_ready_o);
    end
    bus.w_yumi_i = 1;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({bus.w_v_o, bus.w_correct_o, bus.w_clr_o, bus.w_idx_o, bus.w_data_o} !== {3'b110, 6'(10 + k), 8'(8'hA0 + k)}) begin
        errs++;
        $display("FAIL fifo_drain[%0d]: got v=%b cor=%b clr=%b idx=%0d data=%h want 1 1 0 %0d %h", k,
                 bus.w_v_o, bus.w_correct_o, bus.w_clr_o, bus.w_idx_o, bus.w_data_o, 10 + k, 8'hA0 + k);
      end
      tick();
    end
    bus.w_yumi_i = 0;
    vectors++;
    if ({bus.w_v_o, bus.fifo_count_o} !== 4'b0) begin
      errs++;
      $display("FAIL fifo_empty: got v=%b cnt=%0d want 0 0", bus.w_v_o, bus.fifo_count_o);
    end
  endtask
  task automatic test_redirect_priority();
    enqueue(6'd20, 8'h20);
    enqueue(6'd21, 8'h21);
    bus.redir_v_i = 1; bus.redir_idx_i = 6'd7; bus.redir_data_i = 8'h77;
    tick();
    bus.redir_v_i = 0;
    vectors++;
    if ({bus.w_v_o, bus.w_correct_o, bus.w_idx_o, bus.w_data_o, bus.fifo_count_o} !== {2'b10, 6'd7, 8'h77, 3'd2}) begin
      errs++;
      $display("FAIL redir_first: got v=%b cor=%b idx=%0d data=%h cnt=%0d want 1 0 7 77 2",
               bus.w_v_o, bus.w_correct_o, bus.w_idx_o, bus.w_data_o, bus.fifo_count_o);
    end
    bus.w_yumi_i = 1;
    tick();
    vectors++;
    if ({bus.w_v_o, bus.w_correct_o, bus.w_idx_o} !== {2'b11, 6'd20}) begin
      errs++;
      $display("FAIL redir_resume0: got v=%b cor=%b idx=%0d want 1 1 20", bus.w_v_o, bus.w_correct_o, bus.w_idx_o);
    end
    tick();
    vectors++;
    if ({bus.w_v_o, bus.w_correct_o, bus.w_idx_o} !== {2'b11, 6'd21}) begin
      errs++;
      $display("FAIL redir_resume1: got v=%b cor=%b idx=%0d want 1 1 21", bus.w_v_o, bus.w_correct_o, bus.w_idx_o);
    end
    tick();
    bus.w_yumi_i = 0;
    vectors++;
    if (bus.w_v_o !== 1'b0) begin
      errs++;
      $display("FAIL redir_idle: got v=%b want 0", bus.w_v_o);
    end
  endtask
  task automatic test_drop();
    bus.redir_v_i = 1; bus.redir_idx_i = 6'd3; bus.redir_data_i = 8'h33;
    tick();
    bus.redir_idx_i = 6'd9; bus.redir_data_i = 8'h99;
    tick();
    bus.redir_v_i = 0;
    vectors++;
    if ({bus.redir_drop_o, bus.w_v_o, bus.w_idx_o, bus.w_data_o} !== {2'b11, 6'd9, 8'h99}) begin
      errs++;
      $display("FAIL drop_pulse: got drop=%b v=%b idx=%0d data=%h want 1 1 9 99",
               bus.redir_drop_o, bus.w_v_o, bus.w_idx_o, bus.w_data_o);
    end
    tick();
    vectors++;
    if ({bus.redir_drop_o, bus.w_idx_o} !== {1'b0, 6'd9}) begin
      errs++;
      $display("FAIL drop_one_cycle: got drop=%b idx=%0d want 0 9", bus.redir_drop_o, bus.w_idx_o);
    end
    bus.w_yumi_i = 1; bus.redir_v_i = 1; bus.redir_idx_i = 6'd11;
    tick();
    bus.redir_v_i = 0;
    vectors++;
    if ({bus.redir_drop_o, bus.w_v_o, bus.w_idx_o} !== {2'b01, 6'd11}) begin
      errs++;
      $display("FAIL yumi_reload: got drop=%b v=%b idx=%0d want 0 1 11", bus.redir_drop_o, bus.w_v_o, bus.w_idx_o);
    end
    tick();
    bus.w_yumi_i = 0;
    vectors++;
    if (bus.w_v_o !== 1'b0) begin
      errs++;
      $display("FAIL held_cleared: got v=%b want 0", bus.w_v_o);
    end
  endtask
  task automatic test_flush();
    enqueue(6'd1, 8'h01);
    enqueue(6'd2, 8'h02);
    enqueue(6'd3, 8'h03);
    bus.redir_v_i = 1; bus.redir_idx_i = 6'd5;
    tick();
    bus.redir_v_i = 0;
    vectors++;
    if ({bus.w_v_o, bus.w_idx_o, bus.fifo_count_o, bus.att_ready_o} !== {1'b1, 6'd5, 3'd3, 1'b1}) begin
      errs++;
      $display("FAIL flush_setup: got v=%b idx=%0d cnt=%0d rdy=%b want 1 5 3 1",
               bus.w_v_o, bus.w_idx_o, bus.fifo_count_o, bus.att_ready_o);
    end
    bus.flush_i = 1; bus.att_v_i = 1; bus.att_idx_i = 6'd30; bus.redir_v_i = 1; bus.redir_idx_i = 6'd31;
    tick();
    clear_inputs();
    vectors++;
    if ({bus.w_v_o, bus.fifo_count_o, bus.redir_drop_o} !== 5'b0) begin
      errs++;
      $display("FAIL flush: got v=%b cnt=%0d drop=%b want 0 0 0", bus.w_v_o, bus.fifo_count_o, bus.redir_drop_o);
    end
  endtask
  task automatic test_reset_mid();
    enqueue(6'd12, 8'h12);
    bus.redir_v_i = 1; bus.redir_idx_i = 6'd13;
    tick();
    clear_inputs();
    rst_n = 0;
    tick();
    vectors++;
    if ({bus.w_v_o, bus.init_done_o, bus.fifo_count_o} !== 5'b0) begin
      errs++;
      $display("FAIL reset_mid_run: got v=%b done=%b cnt=%0d want 0 0 0", bus.w_v_o, bus.init_done_o, bus.fifo_count_o);
    end
    rst_n = 1; bus.w_yumi_i = 1;
    tick();
    repeat (20) tick();
    vectors++;
    if ({bus.w_v_o, bus.w_clr_o, bus.w_idx_o} !== {2'b11, 6'd20}) begin
      errs++;
      $display("FAIL sweep_at20: got v=%b clr=%b idx=%0d want 1 1 20", bus.w_v_o, bus.w_clr_o, bus.w_idx_o);
    end
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    vectors++;
    if ({bus.w_v_o, bus.w_clr_o, bus.w_idx_o} !== {2'b11, 6'd0}) begin
      errs++;
      $display("FAIL sweep_restart: got v=%b clr=%b idx=%0d want 1 1 0", bus.w_v_o, bus.w_clr_o, bus.w_idx_o);
    end
    bus.flush_i = 1;
    tick();
    bus.flush_i = 0;
    vectors++;
    if ({bus.w_v_o, bus.w_idx_o} !== {1'b1, 6'd1}) begin
      errs++;
      $display("FAIL flush_in_init: got v=%b idx=%0d want 1 1", bus.w_v_o, bus.w_idx_o);
    end
    bus.w_yumi_i = 0;
  endtask
  initial begin
    clear_inputs();
    test_reset();
    test_sweep_fast();
    test_sweep_slow();
    test_fifo_full();
    test_redirect_priority();
    test_drop();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/bp_fe_pred_update_sched.md
BP_FE_PRED_UPDATE_SCHED -- requirements
Module: bp_fe_pred_update_sched

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameter idx_width_p, default 6, predictor table index width (2^idx_width_p entries).
REQ-003 Parameter data_width_p, default 8, table row width.
REQ-004 Parameter fifo_els_p, default 4, attaboy FIFO depth (power of 2, >=2).
REQ-005 Parameter init_val_p, default 8'h55, row value written during the init sweep.
REQ-006 clk_i  in  1  clock.
REQ-007 reset_n_i  in  1  synchronous active-low reset.
REQ-008 init_done_o  out  1  table init sweep complete.
REQ-009 redir_v_i  in  1  mispredict update valid; no ready, always captured.
REQ-010 redir_idx_i / redir_data_i  in  idx_width_p / data_width_p  mispredict update.
REQ-011 redir_drop_o  out  1  pulse: a pending redirect update was overwritten.
REQ-012 att_v_i / att_ready_o  in / out  1 / 1  attaboy (correct-prediction) enqueue handshake.
REQ-013 att_idx_i / att_data_i  in  idx_width_p / data_width_p  attaboy update.
REQ-014 flush_i  in  1  discard all pending updates.
REQ-015 w_v_o  out  1  table write request.
REQ-016 w_idx_o / w_data_o  out  idx_width_p / data_width_p  write address and row.
REQ-017 w_clr_o  out  1  write is an init-sweep clear.
REQ-018 w_correct_o  out  1  1 = attaboy source, 0 = redirect or init.
REQ-019 w_yumi_i  in  1  table accepted the write this cycle; legal only when w_v_o=1.
REQ-020 fifo_count_o  out  clog2(fifo_els_p+1)  attaboy FIFO occupancy.

Function
REQ-021 FSM states SHALL be e_reset, e_init, e_run; reset_n_i=0 forces e_reset in the next cycle.
REQ-022 e_reset SHALL go to e_init unconditionally on the first cycle with reset_n_i=1.
REQ-023 In e_init: w_v_o=1, w_clr_o=1, w_correct_o=0, w_idx_o=sweep counter, w_data_o=init_val_p; the counter advances only on w_yumi_i.
REQ-024 A yumi at counter=2^idx_width_p-1 SHALL move the FSM to e_run; init_done_o is 1 from the next cycle and is held high until reset.
REQ-025 Outside e_run, redir_v_i SHALL be ignored and att_ready_o SHALL be 0; flush_i has no effect on the sweep.
REQ-026 In e_run, redir_v_i SHALL load a one-entry holding register (held_v, idx, data) on the same edge.
REQ-027 Write priority in e_run SHALL be: held redirect, then FIFO head; w_v_o = held_v | (fifo_count_o!=0); w_clr_o=0.
REQ-028 w_correct_o SHALL be 1 only when the FIFO head is presented.
REQ-029 A yumi on the held redirect SHALL clear held_v unless redir_v_i is 1 that cycle, in which case the new update loads and redir_drop_o stays 0.
REQ-030 redir_v_i with held_v=1 and no yumi on the held entry SHALL overwrite the entry and pulse redir_drop_o for one cycle.
REQ-031 att_ready_o SHALL equal e_run & (registered count < fifo_els_p); enqueue on att_v_i & att_ready_o.
REQ-032 A yumi on the FIFO head SHALL dequeue it; simultaneous enqueue and dequeue leave the count unchanged; pointers wrap modulo fifo_els_p.
REQ-033 Outputs SHALL be combinational from registered state; no combinational path from the redir_*/att_* inputs to the w_* outputs.
REQ-034 flush_i SHALL clear held_v and the FIFO next cycle, overriding same-cycle enqueue and redirect capture; a yumi in the flush cycle is still honoured by the table.

Reset
REQ-035 Under reset: FSM=e_reset, sweep counter=0, held_v=0, FIFO empty, init_done_o=0, w_v_o=0, att_ready_o=0, redir_drop_o=0, fifo_count_o=0.
REQ-036 Reset asserted mid-sweep or mid-run SHALL discard all pending state and restart the sweep at index 0.

Verification
REQ-037 Reset, then w_yumi_i tied 1 -> 64 clear writes at idx 0..63 with data 0x55; init_done_o=1 on cycle 66 after reset release.
REQ-038 Sweep with yumi only every 3rd cycle -> every index is written exactly once, in order, with none skipped.
REQ-039 Run, yumi=0, enqueue 5 attaboys -> 4 accepted, att_ready_o=0, fifo_count_o=4; then yumi=1 -> drained in FIFO order with w_correct_o=1.
REQ-040 Run, FIFO holds 2, redir_v_i idx=7 -> next cycle w_idx_o=7, w_correct_o=0; the FIFO resumes after the redirect is yumied.
REQ-041 held_v=1, yumi=0, redir_v_i idx=9 -> redir_drop_o=1 for one cycle; w_idx_o=9.
REQ-042 FIFO holds 3 with held_v=1, assert flush_i together with att_v_i -> next cycle w_v_o=0 and fifo_count_o=0; reset mid-sweep at idx 20 -> the sweep restarts at idx 0.
